// File: rtl/ped_pkg.sv
// Shared light and pedestrian-state codes for the pedestrian signal stage.
// Default WALK/FLASH durations live here so both channels agree.
package ped_pkg;

    typedef enum logic [2:0] {
        RED    = 3'b100,
        YELLOW = 3'b010,
        GREEN  = 3'b001
    } light_t;

    typedef enum logic [1:0] {
        DONT_WALK = 2'b00,
        WALK      = 2'b01,
        FLASH     = 2'b10
    } ped_state_t;

    localparam int DEF_WALK_SEC  = 5;
    localparam int DEF_FLASH_SEC = 4;
    localparam int DEF_CNT_W     = 4;

    function automatic logic is_legal_light(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

endpackage

// File: rtl/ped_channel.sv
// One crosswalk direction: request latch, green-onset detect, WALK/FLASH/DONT_WALK
// sequencing with a tick-driven countdown.
//
// state     | meaning
// DONT_WALK | steady hand, latching requests until the next green onset
// WALK      | walking figure, counting WALK_SEC ticks
// FLASH     | flashing hand, counting FLASH_SEC ticks
module ped_channel
    import ped_pkg::*;
#(
    parameter int WALK_SEC  = DEF_WALK_SEC,
    parameter int FLASH_SEC = DEF_FLASH_SEC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [2:0]       i_light,
    input  logic             i_req,
    input  logic             i_fault_hold,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_count,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_SEC);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ped_state_t       r_state;
    ped_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_pending;
    logic             w_pending_nxt;
    logic [2:0]       r_prev_light;
    logic             w_onset;

    assign w_onset = (i_light == GREEN) && (r_prev_light != GREEN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= DONT_WALK;
            r_count      <= '0;
            r_pending    <= 1'b0;
            r_prev_light <= RED;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_pending    <= w_pending_nxt;
            r_prev_light <= i_light;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_pending_nxt = r_pending;

        if (i_fault_hold) begin
            w_state_nxt   = DONT_WALK;
            w_count_nxt   = '0;
            w_pending_nxt = 1'b0;
        end else begin
            unique case (r_state)
                DONT_WALK: begin
                    if (w_onset && (r_pending || i_req)) begin
                        w_state_nxt   = WALK;
                        w_count_nxt   = WALK_LOAD;
                        w_pending_nxt = 1'b0;
                    end else if (i_req) begin
                        w_pending_nxt = 1'b1;
                    end
                end
                WALK: begin
                    // Red outranks yellow, which outranks the tick countdown.
                    if (i_light == RED) begin
                        w_state_nxt = DONT_WALK;
                        w_count_nxt = '0;
                    end else if (i_light == YELLOW) begin
                        w_state_nxt = FLASH;
                        w_count_nxt = FLASH_LOAD;
                    end else if (i_tick) begin
                        if (r_count > CNT_ONE) begin
                            w_count_nxt = r_count - CNT_ONE;
                        end else begin
                            w_state_nxt = FLASH;
                            w_count_nxt = FLASH_LOAD;
                        end
                    end
                end
                FLASH: begin
                    if (i_light == RED) begin
                        w_state_nxt = DONT_WALK;
                        w_count_nxt = '0;
                    end else if (i_tick) begin
                        if (r_count > CNT_ONE) begin
                            w_count_nxt = r_count - CNT_ONE;
                        end else begin
                            w_state_nxt = DONT_WALK;
                            w_count_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = DONT_WALK;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_count   = r_count;
    assign o_pending = r_pending;

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian signal stage downstream of the NS/EW light controller.
// Two independent crosswalk channels plus a sticky light-conflict fault that forces both to DONT_WALK.
module ped_signal_controller
    import ped_pkg::*;
#(
    parameter int WALK_SEC  = DEF_WALK_SEC,
    parameter int FLASH_SEC = DEF_FLASH_SEC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [2:0]       NS_light,
    input  logic [2:0]       EW_light,
    input  logic             ns_ped_req,
    input  logic             ew_ped_req,
    output logic [1:0]       ns_ped_state,
    output logic [1:0]       ew_ped_state,
    output logic [CNT_W-1:0] ns_ped_count,
    output logic [CNT_W-1:0] ew_ped_count,
    output logic             ns_req_pending,
    output logic             ew_req_pending,
    output logic             fault
);

    logic r_fault;
    logic w_fault_detect;
    logic w_fault_hold;

    assign w_fault_detect = !is_legal_light(NS_light) || !is_legal_light(EW_light) ||
                            ((NS_light != RED) && (EW_light != RED));

    // Include the same-cycle detection so a fault beats a simultaneous onset.
    assign w_fault_hold = r_fault || w_fault_detect;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= w_fault_hold;
        end
    end

    assign fault = r_fault;

    ped_channel #(
        .WALK_SEC  (WALK_SEC),
        .FLASH_SEC (FLASH_SEC),
        .CNT_W     (CNT_W)
    ) u_ns (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (tick),
        .i_light      (NS_light),
        .i_req        (ns_ped_req),
        .i_fault_hold (w_fault_hold),
        .o_state      (ns_ped_state),
        .o_count      (ns_ped_count),
        .o_pending    (ns_req_pending)
    );

    ped_channel #(
        .WALK_SEC  (WALK_SEC),
        .FLASH_SEC (FLASH_SEC),
        .CNT_W     (CNT_W)
    ) u_ew (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (tick),
        .i_light      (EW_light),
        .i_req        (ew_ped_req),
        .i_fault_hold (w_fault_hold),
        .o_state      (ew_ped_state),
        .o_count      (ew_ped_count),
        .o_pending    (ew_req_pending)
    );

endmodule

// File: doc/ped_signal_controller.md
Name: ped_signal_controller

Overview:
- Pedestrian-signal stage that sits directly downstream of the NS/EW traffic-light controller and consumes its one-hot NS_light/EW_light outputs.
- Latches crosswalk button requests for each direction and serves them when that direction's traffic light turns green.
- Serves each request with WALK, then a flashing-hand countdown, then DONT_WALK.
- Checks the incoming light pair for conflicts or illegal codes and forces a sticky safe state when it finds one.

Parameters:
WALK_SEC, 5, number of ticks in WALK
FLASH_SEC, 4, number of ticks in FLASH (flashing hand with countdown)
CNT_W, 4, countdown width; must hold max(WALK_SEC, FLASH_SEC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
tick  in  1  one-cycle 1-second enable pulse
NS_light  in  3  one-hot light code from upstream: red=100, yellow=010, green=001
EW_light  in  3  same encoding as NS_light
ns_ped_req  in  1  NS crosswalk button, level or pulse
ew_ped_req  in  1  EW crosswalk button, level or pulse
ns_ped_state  out  2  00=DONT_WALK, 01=WALK, 10=FLASH (11 never driven)
ew_ped_state  out  2  same encoding as ns_ped_state
ns_ped_count  out  CNT_W  remaining ticks in the current WALK/FLASH; 0 in DONT_WALK
ew_ped_count  out  CNT_W  same for EW
ns_req_pending  out  1  NS request latched and not yet served
ew_req_pending  out  1  EW request latched and not yet served
fault  out  1  sticky light-conflict flag

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-low. Every state update happens on the rising edge of clk.
- Reset (`rst`=0 at a clk edge):
  - both states DONT_WALK, counts 0, pending 0, fault 0.
  - The previous-light registers load red (100), so a green present on the first cycle after reset counts as an onset.
- Each channel uses its own light (NS_light or EW_light).
- Green onset: light==001 this cycle and the registered previous light !=001.
- Request latch:
  - pending sets on any cycle with req=1 while the channel is in DONT_WALK.
  - pending clears on the cycle WALK is entered.
  - req while in WALK or FLASH is ignored.
- DONT_WALK -> WALK: at green onset with (pending | req), WALK is entered on the next edge with count=WALK_SEC. Output latency is 1 cycle from the onset cycle.
- A request that arrives mid-green, after the onset, waits for the next green onset.
- WALK:
  - tick with count>1: count decrements.
  - tick with count==1: go to FLASH with count=FLASH_SEC.
- FLASH:
  - tick with count>1: count decrements.
  - tick with count==1: go to DONT_WALK with count=0.
- Early end of green:
  - light==010 (yellow) while in WALK: go to FLASH with count=FLASH_SEC on the next edge, regardless of tick.
  - light==100 (red) while in WALK or FLASH: go to DONT_WALK with count=0 on the next edge. Red has priority over tick.
- Fault detection, evaluated every cycle outside reset. fault is set on the next edge if either condition holds:
  - either light code is not one of {100, 010, 001};
  - both lights are non-red at the same time.
- While fault=1:
  - both channels are held in DONT_WALK, counts 0, pending 0;
  - requests are ignored;
  - only `rst` clears fault.
- A fault detected in the same cycle as a green onset or a request wins: no WALK is entered.
- Both channels run independently. Upstream guarantees mutually exclusive greens, so simultaneous WALK on both channels can only occur through a fault, which suppresses it.
- Counts never underflow; tick in DONT_WALK has no effect.
- Reset mid-WALK: the channel drops to DONT_WALK on that edge and any pending request is lost.

Decomposition:
- Shared package ped_pkg holds:
  - light codes RED/YELLOW/GREEN;
  - ped-state codes DONT_WALK/WALK/FLASH;
  - the default WALK_SEC/FLASH_SEC.
- Sub-module ped_channel holds one direction: request latch, onset detection, 3-state FSM and countdown. It is instantiated twice, for NS and EW.
- The top level holds fault detection and drives a fault-hold input into both channels.

Test Plan:
- Reset, then NS_light 100->001 with ns_ped_req pulsed 3 cycles earlier -> ns_req_pending=1 until onset; ns_ped_state=01 with count=5 one cycle after onset; after 5 ticks state=10, count=4; after 4 more ticks state=00, count=0.
- No request, NS goes green -> ns_ped_state stays 00. Then ew_ped_req during NS green and EW green onset -> EW WALK with count=5, NS unaffected.
- NS in WALK with count=3, NS_light goes 010 -> next edge state=10, count=4. NS_light goes 100 at count=2 -> next edge state=00, count=0.
- ns_ped_req asserted during WALK -> ns_req_pending stays 0. Asserted mid-green after FLASH ends -> pending=1, served at the next green onset.
- Inject NS_light=001 and EW_light=001 while NS is in WALK -> fault=1 next edge, both states 00, counts 0. Then a legal sequence plus requests -> stays 00 and fault stays 1 until rst=0 at a clk edge.
- Inject NS_light=011 -> fault=1. rst asserted mid-FLASH -> all outputs return to reset values on that edge.
